stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per 10 ms count tick (50 MHz clk); legal range >= 2.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples required to accept a key level change; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port key_start_n, input, 1 bit: raw asynchronous start/pause key, pressed = 0.
REQ-006 The block SHALL have port key_lap_n, input, 1 bit: raw asynchronous lap (display freeze) key, pressed = 0.
REQ-007 The block SHALL have port key_clear_n, input, 1 bit: raw asynchronous clear key, pressed = 0.
REQ-008 The block SHALL have ports hex5, hex4, hex3, hex2, hex1, hex0, each output, 7 bits: active-low segments {g,f,e,d,c,b,a} showing M1 M0 S1 S0 C1 C0 (minutes, seconds, centiseconds).
REQ-009 The block SHALL have port running, output, 1 bit: high in RUN state.
REQ-010 The block SHALL have port frozen, output, 1 bit: high while the display is lap-frozen.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the count rolls 59:59.99 -> 00:00.00.

Function
REQ-012 Each key input SHALL pass through a 2-FF synchroniser, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
REQ-013 Each accepted 1->0 transition SHALL produce exactly one single-cycle internal event; release and bounce SHALL produce no event.
REQ-014 The count SHALL be held as six BCD digits: C0 0-9, C1 0-9, S0 0-9, S1 0-5, M0 0-9, M1 0-5, cascading by carry.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and SHALL hold its value in IDLE and PAUSE.
REQ-016 On the edge where state is RUN and prescaler = TICK_DIV-1, the prescaler SHALL return to 0 and the count SHALL increment by one centisecond.
REQ-017 Incrementing from 59:59.99 SHALL give 00:00.00, assert wrap for exactly that one cycle, and keep state RUN.
REQ-018 The FSM SHALL have states IDLE, RUN, PAUSE; start event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-019 A clear event SHALL, from any state, zero count and prescaler, deassert frozen, and enter IDLE.
REQ-020 A lap event in RUN SHALL toggle frozen; in IDLE or PAUSE it SHALL deassert frozen.
REQ-021 If events coincide in one cycle, clear SHALL take priority; start and lap together SHALL both be applied, with lap evaluated against the pre-transition state.
REQ-022 The display register SHALL copy the count every cycle while frozen = 0 (one-cycle lag) and SHALL hold while frozen = 1; counting continues underneath.
REQ-023 hexN SHALL be combinational decodes of the display register: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 running SHALL equal (state == RUN) registered with the state.

Reset
REQ-025 While rst_n = 0 at a rising clk edge, state SHALL become IDLE and count, prescaler, display register, frozen, wrap, and debouncer counters SHALL become 0, with debounced key levels set to 1 (released).
REQ-026 After reset, all hex outputs SHALL read 1000000 and running = 0.
REQ-027 Reset mid-RUN or mid-debounce SHALL discard any partial tick or pending key event.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=2)
REQ-028 Reset, then press start: running = 1 within 5 cycles; after 40 more cycles count = 00:00.10 and hex1 = 1111001, hex0 = 1000000.
REQ-029 Key bouncing 0/1 every cycle for 10 cycles, then held low: exactly one start event, state RUN.
REQ-030 Preload 59:59.98 via run time, RUN: after 8 cycles display 00:00.00 and wrap pulses high for exactly 1 cycle.
REQ-031 RUN at 00:00.05, press lap: display holds 00:00.05 while count advances; second lap: display shows live count next cycle.
REQ-032 RUN with start and clear pressed in the same cycle: state IDLE, count 00:00.00, running = 0.
REQ-033 Pause at prescaler = 2, resume: next tick occurs exactly 2 cycles after resume.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/lap/clear keys, 6-digit BCD mm:ss.cc count,
// lap-freeze display register and seven-segment decode.

module stopwatch_key #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // The stable-sample run restarts whenever the synchronised level matches the accepted one.
    always_comb begin
        accept  = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = '0;
        level_d = level_q;
        if (accept)
            level_d = sync2_q;
        else if (sync2_q != level_q)
            cnt_d = cnt_q + 1'b1;
    end

    assign press_o = accept && !sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       key_clear_n,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       running,
    output logic       frozen,
    output logic       wrap
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    // Digit order is C0, C1, S0, S1, M0, M1 from index 0 upward.
    localparam logic [5:0][3:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0][3:0] cnt_q, cnt_d, cnt_inc, disp_q;
    logic            frozen_q, frozen_d;
    logic            wrap_q, wrap_d;
    logic            running_q;
    logic            tick, carry;
    logic [2:0]      keys_n, press;

    assign keys_n = {key_clear_n, key_lap_n, key_start_n};

    for (genvar i = 0; i < 3; i++) begin : g_key
        stopwatch_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .key_n_i (keys_n[i]),
            .press_o (press[i])
        );
    end

    always_comb begin
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (cnt_q[i] == DMAX[i]) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    // Lap is judged against the state before any start transition this cycle; clear overrides all.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        frozen_d = frozen_q;
        wrap_d   = 1'b0;
        tick     = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
        if (state_q == S_RUN)
            presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
            cnt_d  = cnt_inc;
            wrap_d = (cnt_q == DMAX);
        end
        if (press[1])
            frozen_d = (state_q == S_RUN) ? !frozen_q : 1'b0;
        if (press[0]) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
        if (press[2]) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            presc_d  = '0;
            frozen_d = 1'b0;
            wrap_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            frozen_q  <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            if (!frozen_q)
                disp_q <= cnt_q;
            frozen_q  <= frozen_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == S_RUN);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign hex0    = seg7(disp_q[0]);
    assign hex1    = seg7(disp_q[1]);
    assign hex2    = seg7(disp_q[2]);
    assign hex3    = seg7(disp_q[3]);
    assign hex4    = seg7(disp_q[4]);
    assign hex5    = seg7(disp_q[5]);
    assign running = running_q;
    assign frozen  = frozen_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=2: stimulus queues
// hand-computed expectations, a negedge monitor pops and compares them.

module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ks = 1'b1, kl = 1'b1, kc = 1'b1;
    logic [6:0] h5, h4, h3, h2, h1, h0;
    logic       running, frozen, wrap;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start_n(ks), .key_lap_n(kl), .key_clear_n(kc),
        .hex5(h5), .hex4(h4), .hex3(h3), .hex2(h2), .hex1(h1), .hex0(h0),
        .running(running), .frozen(frozen), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // sel: 0 hex bus, 1 running, 2 frozen, 3 wrap, 4 wrap pulses seen, 5 clear pulse counter
    typedef struct {
        string       name;
        int          sel;
        logic [41:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   wrap_seen = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] hexv(input int m1, m0, s1, s0, c1, c0);
        return {seg(m1), seg(m0), seg(s1), seg(s0), seg(c1), seg(c0)};
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [41:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ks = 1'b1; kl = 1'b1; kc = 1'b1;
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [41:0] act;
        if (wrap) wrap_seen++;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel == 5) begin
                wrap_seen = 0;
            end else begin
                case (e.sel)
                    0:       act = {h5, h4, h3, h2, h1, h0};
                    1:       act = 42'(running);
                    2:       act = 42'(frozen);
                    3:       act = 42'(wrap);
                    default: act = 42'(wrap_seen);
                endcase
                n_checks++;
                if (act !== e.val) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        n_checks++;
        if ({h5, h4, h3, h2, h1, h0} !== hexv(0, 0, 0, 0, 0, 0) || running !== 1'b0 ||
            frozen !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_direct: hex %h running %b frozen %b wrap %b",
                     {h5, h4, h3, h2, h1, h0}, running, frozen, wrap);
        end
        expect_v("reset_hex", 0, hexv(0, 0, 0, 0, 0, 0));
        expect_v("reset_running", 1, 42'd0);
        expect_v("reset_frozen", 2, 42'd0);
        expect_v("reset_wrap", 3, 42'd0);

        // Start, then count ten ticks
        ks = 1'b0;
        step(5);
        expect_v("start_running", 1, 42'd1);
        step(1);
        ks = 1'b1;
        step(40);
        expect_v("count_10", 0, hexv(0, 0, 0, 0, 1, 0));

        // Reset mid-run with a start press half-debounced
        ks = 1'b0;
        step(2);
        rst_n = 1'b0;
        ks = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(10);
        expect_v("midrst_running", 1, 42'd0);
        expect_v("midrst_hex", 0, hexv(0, 0, 0, 0, 0, 0));

        // Bouncing start key: exactly one event
        do_reset();
        for (int j = 0; j < 10; j++) begin
            ks = (j % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        expect_v("bounce_no_evt", 1, 42'd0);
        ks = 1'b0;
        step(8);
        expect_v("bounce_run", 1, 42'd1);
        step(10);
        ks = 1'b1;
        step(10);
        expect_v("bounce_still_run", 1, 42'd1);

        // Rollover from 59:59.98 (count preloaded while idle)
        do_reset();
        expect_v("wrap_cnt_clr", 5, 42'd0);
        force dut.cnt_q = 24'h595998;
        step(1);
        release dut.cnt_q;
        step(1);
        expect_v("preload_hex", 0, hexv(5, 9, 5, 9, 9, 8));
        ks = 1'b0;
        step(6);
        ks = 1'b1;
        step(4);
        expect_v("pre_wrap_hex", 0, hexv(5, 9, 5, 9, 9, 9));
        expect_v("pre_wrap_low", 3, 42'd0);
        step(4);
        expect_v("post_wrap_hex", 0, hexv(0, 0, 0, 0, 0, 0));
        expect_v("post_wrap_run", 1, 42'd1);
        step(6);
        expect_v("wrap_one_pulse", 4, 42'd1);

        // Lap freeze and release
        do_reset();
        ks = 1'b0;
        step(6);
        ks = 1'b1;
        step(16);
        kl = 1'b0;
        step(6);
        kl = 1'b1;
        expect_v("lap_hold_hex", 0, hexv(0, 0, 0, 0, 0, 5));
        expect_v("lap_frozen", 2, 42'd1);
        step(12);
        expect_v("lap_still_hex", 0, hexv(0, 0, 0, 0, 0, 5));
        kl = 1'b0;
        step(4);
        expect_v("unlap_frozen", 2, 42'd0);
        expect_v("unlap_lag_hex", 0, hexv(0, 0, 0, 0, 0, 5));
        step(1);
        expect_v("unlap_live_hex", 0, hexv(0, 0, 0, 0, 1, 0));
        kl = 1'b1;
        step(10);

        // Start and clear in the same cycle: clear wins
        do_reset();
        ks = 1'b0;
        step(6);
        ks = 1'b1;
        step(24);
        ks = 1'b0;
        kc = 1'b0;
        step(6);
        ks = 1'b1;
        kc = 1'b1;
        step(1);
        expect_v("clr_running", 1, 42'd0);
        expect_v("clr_hex", 0, hexv(0, 0, 0, 0, 0, 0));
        step(10);
        expect_v("clr_idle_running", 1, 42'd0);
        expect_v("clr_idle_hex", 0, hexv(0, 0, 0, 0, 0, 0));
        expect_v("clr_frozen", 2, 42'd0);

        // Pause with prescaler at 2, resume: tick two cycles later
        do_reset();
        ks = 1'b0;
        step(6);
        ks = 1'b1;
        step(8);
        ks = 1'b0;
        step(6);
        ks = 1'b1;
        step(5);
        expect_v("pause_running", 1, 42'd0);
        step(3);
        expect_v("pause_hex", 0, hexv(0, 0, 0, 0, 0, 3));
        step(2);
        ks = 1'b0;
        step(5);
        expect_v("resume_running", 1, 42'd1);
        expect_v("resume_hex", 0, hexv(0, 0, 0, 0, 0, 3));
        step(1);
        expect_v("resume_r1_hex", 0, hexv(0, 0, 0, 0, 0, 3));
        step(1);
        expect_v("resume_tick_hex", 0, hexv(0, 0, 0, 0, 0, 4));
        ks = 1'b1;
        step(5);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
